// File: rtl/gdsp_pkg.sv
// Shared types and constants for the 16-QAM transmit datapath.
// Rates, symbol width and scheduler state encoding live here.
package gdsp_pkg;

  localparam int SPS          = 4;
  localparam int BITS_PER_SYM = 4;
  localparam int NUM_TAPS     = 5;
  localparam int TX_CLK_DIV   = 27;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } tx_state_t;

  typedef logic [BITS_PER_SYM-1:0] sym_t;

endpackage

// File: rtl/tx_sample_scheduler_strobe_divider.sv
// Modulo-DIV counter with enable/clear and a terminal-count pulse.
// Reusable wherever a slow rate strobe is derived from clk.
module strobe_divider #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/tx_sample_scheduler.sv
// Sample/symbol pacing for the QAM mapper + RRC FIR chain.
// Run/stop FSM, phase counter and one-entry symbol prefetch slot.
module tx_sample_scheduler #(
  parameter int CLK_DIV       = gdsp_pkg::TX_CLK_DIV,
  parameter int SPS           = gdsp_pkg::SPS,
  parameter int SYM_W         = gdsp_pkg::BITS_PER_SYM,
  parameter int FLUSH_SAMPLES = gdsp_pkg::NUM_TAPS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run_i,
  input  logic                    sym_valid_i,
  input  logic [SYM_W-1:0]        sym_data_i,
  output logic                    sym_ready_o,
  output logic                    samp_stb_o,
  output logic                    sym_stb_o,
  output logic [SYM_W-1:0]        sym_o,
  output logic                    zero_stuff_o,
  output logic [$clog2(SPS)-1:0]  phase_o,
  output logic                    busy_o,
  output logic                    underrun_o,
  input  logic                    underrun_clr_i
);

  import gdsp_pkg::*;

  localparam int PW = $clog2(SPS);
  localparam int FW = $clog2(FLUSH_SAMPLES + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SPS - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FLUSH_SAMPLES - 1);

  tx_state_t        state;
  logic             tc;
  logic             stop_req;
  logic             slot_full;
  logic [SYM_W-1:0] slot;
  logic [PW-1:0]    ph;
  logic [FW-1:0]    fcnt;
  logic             xfer;
  logic             sym_slot;
  logic             take;
  logic             stopping;

  strobe_divider #(
    .DIV(CLK_DIV)
  ) u_div (
    .clk(clk),
    .rst(rst),
    .en (state != IDLE),
    .clr(state == IDLE),
    .tc (tc)
  );

  assign sym_ready_o = (state == RUN) && !slot_full;
  assign busy_o      = (state != IDLE);
  assign xfer        = sym_valid_i && sym_ready_o;
  assign sym_slot    = tc && (state == RUN) && (ph == '0);
  assign take        = sym_slot && slot_full;
  assign stopping    = stop_req || !run_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ph           <= '0;
      fcnt         <= '0;
      stop_req     <= 1'b0;
      slot_full    <= 1'b0;
      slot         <= '0;
      samp_stb_o   <= 1'b0;
      sym_stb_o    <= 1'b0;
      sym_o        <= '0;
      zero_stuff_o <= 1'b1;
      phase_o      <= '0;
      underrun_o   <= 1'b0;
    end else begin
      samp_stb_o <= tc;
      sym_stb_o  <= take;
      if (tc) begin
        phase_o      <= ph;
        ph           <= ph + PW'(1);
        zero_stuff_o <= !take;
      end
      if (take) begin
        sym_o     <= slot;
        slot_full <= 1'b0;
      end else if (xfer) begin
        slot      <= sym_data_i;
        slot_full <= 1'b1;
      end
      if (sym_slot && !slot_full) begin
        underrun_o <= 1'b1;
      end else if (underrun_clr_i) begin
        underrun_o <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (run_i) begin
            state <= RUN;
            ph    <= '0;
          end
        end
        RUN: begin
          // stop request is sticky so a short run_i drop still ends the burst
          if (!run_i) stop_req <= 1'b1;
          if (tc && (ph == PH_LAST) && stopping) begin
            state    <= FLUSH;
            stop_req <= 1'b0;
            fcnt     <= '0;
          end
        end
        FLUSH: begin
          if (tc) begin
            fcnt <= fcnt + FW'(1);
            if (fcnt == FL_LAST) begin
              state     <= IDLE;
              slot_full <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_sample_scheduler.sv
// Random-stimulus bench for tx_sample_scheduler (4/4/5 and 2/2/5 builds)
// against a sample-count based behavioural model.
module tb_tx_sample_scheduler;

  localparam int FL = 5;

  typedef struct {
    int       mode;
    int       t;
    int       n;
    int       nfl;
    bit       stop;
    bit       full;
    bit [3:0] slot;
    bit       samp;
    bit       stb;
    bit       zs;
    bit       und;
    bit [3:0] sym;
    int       ph;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] run;
  logic [1:0] vld;
  logic [1:0] clr;
  logic [1:0] rdy;
  logic [3:0] dat [2];
  logic [3:0] nx  [2];
  bit   [1:0] acc;

  logic       samp0, stb0, zs0, busy0, und0;
  logic [3:0] sym0;
  logic [1:0] ph0;
  logic       samp1, stb1, zs1, busy1, und1;
  logic [3:0] sym1;
  logic [0:0] ph1;

  mdl_t m0, m1;
  int total = 0;
  int bad = 0;
  int pv, pdrop, pclr;
  bit rforce, rval;

  always #5 clk = ~clk;

  tx_sample_scheduler #(
    .CLK_DIV(4), .SPS(4), .SYM_W(4), .FLUSH_SAMPLES(FL)
  ) u0 (
    .clk(clk), .rst(rst), .run_i(run[0]),
    .sym_valid_i(vld[0]), .sym_data_i(dat[0]),
    .sym_ready_o(rdy[0]), .samp_stb_o(samp0),
    .sym_stb_o(stb0), .sym_o(sym0),
    .zero_stuff_o(zs0), .phase_o(ph0),
    .busy_o(busy0), .underrun_o(und0),
    .underrun_clr_i(clr[0])
  );

  tx_sample_scheduler #(
    .CLK_DIV(2), .SPS(2), .SYM_W(4), .FLUSH_SAMPLES(FL)
  ) u1 (
    .clk(clk), .rst(rst), .run_i(run[1]),
    .sym_valid_i(vld[1]), .sym_data_i(dat[1]),
    .sym_ready_o(rdy[1]), .samp_stb_o(samp1),
    .sym_stb_o(stb1), .sym_o(sym1),
    .zero_stuff_o(zs1), .phase_o(ph1),
    .busy_o(busy1), .underrun_o(und1),
    .underrun_clr_i(clr[1])
  );

  function automatic mdl_t mreset();
    mdl_t r;
    r.mode = 0; r.t = 0; r.n = 0; r.nfl = 0;
    r.stop = 0; r.full = 0; r.slot = '0;
    r.samp = 0; r.stb = 0; r.zs = 1; r.und = 0;
    r.sym = '0; r.ph = 0;
    return r;
  endfunction

  // one clock of the schedule: samples every cd clocks, symbol every sps samples
  function automatic mdl_t mstep(mdl_t m, int cd, int sps, bit rn,
                                 bit v, bit [3:0] d, bit c);
    mdl_t r = m;
    bit ev, rd, uset;
    int k;
    rd   = (m.mode == 1) && !m.full;
    ev   = (m.mode != 0) && ((m.t % cd) == cd - 1);
    k    = m.n % sps;
    uset = 0;
    r.samp = ev;
    r.stb  = 0;
    if (ev) begin
      r.ph = k;
      r.zs = 1;
      if (m.mode == 1 && k == 0) begin
        if (m.full) begin
          r.sym = m.slot; r.stb = 1; r.zs = 0; r.full = 0;
        end else begin
          uset = 1;
        end
      end
    end
    if (uset) r.und = 1;
    else if (c) r.und = 0;
    if (v && rd) begin
      r.full = 1; r.slot = d;
    end
    case (m.mode)
      0: if (rn) begin
        r.mode = 1; r.t = 0; r.n = 0; r.stop = 0;
      end
      1: begin
        r.t = m.t + 1;
        r.stop = m.stop || !rn;
        if (ev) begin
          r.n = m.n + 1;
          if (k == sps - 1 && r.stop) begin
            r.mode = 2; r.nfl = 0;
          end
        end
      end
      default: begin
        r.t = m.t + 1;
        if (ev) begin
          r.n = m.n + 1;
          r.nfl = m.nfl + 1;
          if (r.nfl == FL) begin
            r.mode = 0; r.full = 0;
          end
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [11:0] pk(mdl_t m);
    return {m.mode == 1 && !m.full, m.samp, m.stb, m.sym,
            m.zs, 2'(m.ph), m.mode != 0, m.und};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 = mreset();
      m1 = mreset();
    end else begin
      m0 = mstep(m0, 4, 4, run[0], vld[0], dat[0], clr[0]);
      m1 = mstep(m1, 2, 2, run[1], vld[1], dat[1], clr[1]);
    end
  end

  wire [11:0] got0 = {rdy[0], samp0, stb0, sym0, zs0, ph0, busy0, und0};
  wire [11:0] got1 = {rdy[1], samp1, stb1, sym1, zs1, 1'b0, ph1, busy1, und1};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("u0", 32'(got0), 32'(pk(m0)));
    chk("u1", 32'(got1), 32'(pk(m1)));
    for (int i = 0; i < 2; i++) begin
      if (!(vld[i] && !acc[i])) begin
        vld[i] = $urandom_range(99) < pv;
        if (vld[i]) begin
          dat[i] = nx[i];
          nx[i]  = nx[i] + 4'd1;
        end
      end
      run[i] = rforce ? rval : ($urandom_range(99) >= pdrop);
      clr[i] = $urandom_range(99) < pclr;
      acc[i] = vld[i] && rdy[i];
    end
  endtask

  task automatic arst();
    #2 rst = 1'b1;
    #1;
    chk("arst0", 32'(got0), 32'h010);
    chk("arst1", 32'(got1), 32'h010);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    rst = 1'b1;
    run = '0; vld = '0; clr = '0; acc = '0;
    dat[0] = '0; dat[1] = '0;
    nx[0] = 4'd1; nx[1] = 4'd1;
    pv = 0; pdrop = 0; pclr = 0;
    rforce = 1; rval = 0;
    repeat (3) tick();
    chk("rst0", 32'(got0), 32'h010);
    rst = 1'b0;
    tick();

    // continuous run, source always valid
    pv = 100; rval = 1;
    tick();
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!samp0 && lat < 20);
    chk("first_samp", 32'(lat), 32'd5);
    repeat (100) tick();
    chk("no_und", 32'(und0), 32'd0);

    // starve the source, then clear underrun
    pv = 0; pclr = 30;
    repeat (120) tick();
    pclr = 0;
    repeat (20) tick();
    chk("und_set", 32'(und0), 32'd1);
    pv = 100;
    repeat (20) tick();
    pclr = 100;
    tick();
    pclr = 0;
    tick();
    chk("und_clr", 32'(und0), 32'd0);

    // graceful stop and drain
    pv = 70; rval = 0;
    n = 0;
    while (busy0 && n < 80) begin
      tick();
      n++;
    end
    chk("stop_idle", 32'(busy0), 32'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n += int'(samp0);
    end
    chk("idle_quiet", 32'(n), 32'd0);

    // brief run_i drops with run otherwise held high
    rforce = 0; pdrop = 8; pv = 80; pclr = 5;
    repeat (500) tick();

    // async reset mid-symbol with the slot full
    rforce = 1; rval = 1; pv = 100;
    repeat (20) tick();
    n = 0;
    while (!(ph0 == 2'd2 && !rdy[0] && busy0) && n < 40) begin
      tick();
      n++;
    end
    chk("pre_arst", 32'({ph0, rdy[0], busy0}), 32'b1001);
    arst();
    repeat (60) tick();

    // long mixed random run with occasional resets
    rforce = 0; pdrop = 4; pv = 60; pclr = 5;
    for (int k = 0; k < 5; k++) begin
      repeat (300 + $urandom_range(50)) tick();
      arst();
    end
    repeat (50) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
